// File: rtl/str_to_num_gen_pkg.sv
// Shared definitions for the ASCII-to-integer stream parser: FSM state
// encodings, ASCII code points, radix constants and a small helper.
package str_to_num_gen_pkg;

  // Parser states; EMIT is the only state that back-pressures the input
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SIGN = 3'd1,
    ST_ZERO = 3'd2,
    ST_HEXP = 3'd3,
    ST_DEC  = 3'd4,
    ST_HEX  = 3'd5,
    ST_EMIT = 3'd6
  } state_t;

  // ASCII code points the parser cares about
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LF    = 8'h66;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_UF    = 8'h46;
  localparam logic [7:0] ASCII_LX    = 8'h78;
  localparam logic [7:0] ASCII_UX    = 8'h58;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  // Multiplier applied to the accumulator per accepted digit
  localparam logic [4:0] RADIX_DEC = 5'd10;
  localparam logic [4:0] RADIX_HEX = 5'd16;

  // True for the second character of a "0x"/"0X" prefix
  function automatic logic is_hex_marker(input logic [7:0] c);
    return (c == ASCII_LX) || (c == ASCII_UX);
  endfunction

endpackage

// File: rtl/str_to_num_gen_ascii_digit_decode.sv
// Combinational ASCII digit classifier. Decimal digits are always
// recognised; letters a-f / A-F only count as digits in hex mode.
module ascii_digit_decode
  import str_to_num_gen_pkg::*;
(
  input  logic [7:0] i_char,
  input  logic       i_hex_mode,
  output logic       o_is_dec,
  output logic       o_is_hex,
  output logic [3:0] o_val
);

  logic w_dec_range;
  logic w_alpha_range;

  assign w_dec_range   = (i_char >= ASCII_0) && (i_char <= ASCII_9);
  assign w_alpha_range = ((i_char >= ASCII_LA) && (i_char <= ASCII_LF)) ||
                         ((i_char >= ASCII_UA) && (i_char <= ASCII_UF));

  // Classify the character and produce its digit value. The low nibble of
  // '0'-'9' is the digit itself; for 'a'/'A' (low nibble 1) adding 9 gives 10.
  always_comb begin
    o_is_dec = 1'b0;
    o_is_hex = 1'b0;
    o_val    = 4'd0;
    if (w_dec_range) begin
      o_is_dec = 1'b1;
      o_is_hex = 1'b1;
      o_val    = i_char[3:0];
    end else if (i_hex_mode && w_alpha_range) begin
      o_is_dec = 1'b0;
      o_is_hex = 1'b1;
      o_val    = i_char[3:0] + 4'd9;
    end else begin
      o_is_dec = 1'b0;
      o_is_hex = 1'b0;
      o_val    = 4'd0;
    end
  end

endmodule

// File: rtl/str_to_num_gen.sv
// Streaming ASCII number parser: turns a valid/ready character stream into
// one W-bit integer per token (decimal, optional 0x-hex, optional '-'),
// with a sticky overflow flag delivered alongside each value.
module str_to_num_gen
  import str_to_num_gen_pkg::*;
#(
  parameter int W         = 32,
  parameter bit HEX_EN    = 1'b1,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_dtm,
  input  logic         s_vld,
  output logic         s_rdy,
  output logic [W-1:0] n_dtm,
  output logic         n_vld,
  input  logic         n_rdy,
  output logic         n_ovf
);

  // Largest magnitude a negative W-bit result can represent (2^(W-1))
  localparam logic [W-1:0] NEG_MAG_LIMIT = {1'b1, {(W-1){1'b0}}};

  state_t       r_state;
  logic [W-1:0] r_acc;
  logic         r_neg;
  logic         r_ovf;
  logic         r_n_vld;
  logic [W-1:0] r_n_dtm;
  logic         r_n_ovf;

  logic         w_hex_mode;
  logic         w_is_dec;
  logic         w_is_hex;
  logic [3:0]   w_val;
  logic [W-1:0] w_val_ext;
  logic [4:0]   w_radix;
  logic [W+4:0] w_prod;
  logic         w_prod_ovf;
  logic         w_is_minus;
  logic         w_is_x;
  logic         w_neg_big;
  logic [W-1:0] w_out_dtm;
  logic         w_out_ovf;
  logic         w_go_emit;

  // Letters are digits only once a "0x" prefix has been seen
  assign w_hex_mode = (r_state == ST_HEXP) || (r_state == ST_HEX);

  ascii_digit_decode u_digit (
    .i_char     (s_dtm),
    .i_hex_mode (w_hex_mode),
    .o_is_dec   (w_is_dec),
    .o_is_hex   (w_is_hex),
    .o_val      (w_val)
  );

  assign w_val_ext  = {{(W-4){1'b0}}, w_val};
  assign w_is_minus = SIGNED_EN && (s_dtm == ASCII_MINUS);
  assign w_is_x     = HEX_EN && is_hex_marker(s_dtm);

  // acc*radix+digit computed 5 bits wider so the true result is visible;
  // anything above bit W-1 means the token no longer fits.
  assign w_radix    = (r_state == ST_HEX) ? RADIX_HEX : RADIX_DEC;
  assign w_prod     = ({5'd0, r_acc} * {{W{1'b0}}, w_radix}) +
                      {{(W+1){1'b0}}, w_val};
  assign w_prod_ovf = |w_prod[W+4:W];

  // Negative results: magnitude beyond 2^(W-1) cannot be represented
  assign w_neg_big = r_neg && (r_acc > NEG_MAG_LIMIT);
  assign w_out_dtm = r_neg ? (~r_acc + {{(W-1){1'b0}}, 1'b1}) : r_acc;
  assign w_out_ovf = r_ovf | w_neg_big;

  // Detect an accepted character that terminates the open token
  always_comb begin
    w_go_emit = 1'b0;
    if (s_vld) begin
      case (r_state)
        ST_ZERO: w_go_emit = !w_is_x && !w_is_dec;
        ST_HEXP: w_go_emit = !w_is_hex;
        ST_DEC:  w_go_emit = !w_is_dec;
        ST_HEX:  w_go_emit = !w_is_hex;
        default: w_go_emit = 1'b0;
      endcase
    end else begin
      w_go_emit = 1'b0;
    end
  end

  // Parser FSM, accumulator, overflow tracking and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= {W{1'b0}};
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_n_vld <= 1'b0;
      r_n_dtm <= {W{1'b0}};
      r_n_ovf <= 1'b0;
    end else if (w_go_emit) begin
      // Terminator consumed: latch the finished value for the output side
      r_state <= ST_EMIT;
      r_n_vld <= 1'b1;
      r_n_dtm <= w_out_dtm;
      r_n_ovf <= w_out_ovf;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_vld) begin
            if (w_is_dec) begin
              r_acc   <= w_val_ext;
              r_state <= (w_val == 4'd0) ? ST_ZERO : ST_DEC;
            end else if (w_is_minus) begin
              r_state <= ST_SIGN;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_SIGN: begin
          // A '-' only sticks if a digit follows it immediately
          if (s_vld) begin
            if (w_is_dec) begin
              r_neg   <= 1'b1;
              r_acc   <= w_val_ext;
              r_state <= (w_val == 4'd0) ? ST_ZERO : ST_DEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_ZERO: begin
          if (s_vld) begin
            if (w_is_x) begin
              r_state <= ST_HEXP;
            end else begin
              r_acc   <= w_val_ext;
              r_state <= ST_DEC;
            end
          end
        end
        ST_HEXP: begin
          if (s_vld) begin
            r_acc   <= w_val_ext;
            r_state <= ST_HEX;
          end
        end
        ST_DEC, ST_HEX: begin
          if (s_vld) begin
            r_acc <= w_prod[W-1:0];
            r_ovf <= r_ovf | w_prod_ovf;
          end
        end
        ST_EMIT: begin
          if (n_rdy) begin
            r_state <= ST_IDLE;
            r_n_vld <= 1'b0;
            r_acc   <= {W{1'b0}};
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_n_vld <= 1'b0;
          r_acc   <= {W{1'b0}};
          r_neg   <= 1'b0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end

  // Input side is blocked only while a value waits to be taken
  assign s_rdy = !rst && (r_state != ST_EMIT);
  assign n_vld = r_n_vld;
  assign n_dtm = r_n_dtm;
  assign n_ovf = r_n_ovf;

endmodule
